sp_ram_fifo: RTL and testbench



---
 rtl/sp_ram_fifo_pkg.sv | 22 ++
 rtl/sp_ram_fifo_if.sv | 31 +++
 rtl/sp_ram_fifo_sp_ram.sv | 39 +++
 rtl/sp_ram_fifo.sv | 94 +++++++++
 tb/tb_sp_ram_fifo.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_fifo_pkg
// Description : Shared widths and RAM-operation encoding for the
//               single-port-RAM FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    // The one operation the single RAM port performs in a given cycle
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } ram_op_e;

endpackage
`default_nettype wire

// File: rtl/sp_ram_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_fifo_if
// Description : Push/pop streaming interface of the single-port-RAM FIFO.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_ram_fifo_if;
    import sp_ram_fifo_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, empty
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/sp_ram_fifo_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram
// Description : 32x8 single-port synchronous RAM with a registered read
//               port. q only changes on a read; writes leave it untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram
    import sp_ram_fifo_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic              we,
    input  wire logic              re,
    input  wire logic [DATA_W-1:0] d,
    output logic      [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage array: written on we, never reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= d;
        end
    end

    // Registered read port, cleared by reset, loaded only on re
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (re) begin
            q <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_fifo
// Description : Byte FIFO on one single-port RAM. Reads have priority over
//               writes; the RAM read register is the FIFO output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_fifo
    import sp_ram_fifo_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     resetn,
    sp_ram_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_out_valid;

    logic              w_rd_issue;
    logic              w_in_ready;
    logic              w_wr;
    logic              w_pop;
    ram_op_e           w_op;
    logic [ADDR_W-1:0] w_addr;

    // Arbitration: refill the output register whenever it is free or being
    // consumed; writes only get the port when no read is needed.
    always_comb begin
        w_rd_issue = (r_ram_cnt != '0) && (!r_out_valid || bus.out_ready);
        w_in_ready = !w_rd_issue && (r_ram_cnt != C_FULL_CNT);
        w_wr       = bus.in_valid && w_in_ready;
        w_pop      = r_out_valid && bus.out_ready;
        if (w_rd_issue) begin
            w_op = OP_READ;
        end else if (w_wr) begin
            w_op = OP_WRITE;
        end else begin
            w_op = OP_IDLE;
        end
        w_addr = (w_op == OP_READ) ? r_rd_ptr : r_wr_ptr;
    end

    // Pointer, occupancy and output-valid bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (w_op)
                OP_READ: begin
                    r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                    r_ram_cnt   <= r_ram_cnt - (ADDR_W + 1)'(1);
                    r_out_valid <= 1'b1;
                end
                OP_WRITE: begin
                    r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                    r_ram_cnt <= r_ram_cnt + (ADDR_W + 1)'(1);
                    if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    sp_ram u_ram (
        .clk    (clk),
        .resetn (resetn),
        .addr   (w_addr),
        .we     (w_op == OP_WRITE),
        .re     (w_op == OP_READ),
        .d      (bus.in_data),
        .q      (bus.out_data)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.count     = r_ram_cnt + {{ADDR_W{1'b0}}, r_out_valid};
    assign bus.full      = (r_ram_cnt == C_FULL_CNT);
    assign bus.empty     = (r_ram_cnt == '0) && !r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_fifo
// Description : Self-checking bench for sp_ram_fifo. A queue-based model of
//               the FIFO predicts every output each cycle; a second queue
//               holds all accepted words to confirm strict FIFO order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_fifo;

    logic clk;
    logic resetn;
    int   n_total;
    int   n_bad;

    sp_ram_fifo_if bus ();

    sp_ram_fifo dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: words held in RAM, plus the output register
    logic [7:0] ram_q[$];
    logic [7:0] exp_stream[$];
    bit         m_ov;
    logic [7:0] m_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        exp_stream.delete();
        m_ov = 1'b0;
        m_q  = 8'h00;
    endtask

    // One clock cycle: drive, check against model, advance model at the edge
    task automatic cycle(input bit iv, input logic [7:0] d, input bit ordy, output bit acc);
        bit rd;
        bit rdy;
        bit pop;
        int held;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        held = ram_q.size();
        rd   = (held != 0) && (!m_ov || ordy);
        rdy  = !rd && (held != 32);
        pop  = m_ov && ordy;
        acc  = iv && rdy;
        check("in_ready",  32'(bus.in_ready),  32'(rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_data",  32'(bus.out_data),  32'(m_q));
        check("count",     32'(bus.count),     32'(held + int'(m_ov)));
        check("full",      32'(bus.full),      32'(held == 32));
        check("empty",     32'(bus.empty),     32'((held == 0) && !m_ov));
        if (pop && exp_stream.size() != 0) begin
            check("order", 32'(bus.out_data), 32'(exp_stream.pop_front()));
        end
        if (acc) begin
            exp_stream.push_back(d);
        end
        @(posedge clk);
        if (rd) begin
            m_q  = ram_q.pop_front();
            m_ov = 1'b1;
        end else if (pop) begin
            m_ov = 1'b0;
        end
        if (acc) begin
            ram_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 80; i++) begin
            if (ram_q.size() == 0 && !m_ov) break;
            cycle(1'b0, 8'h00, 1'b1, acc);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        bit         acc;
        int         v;
        int         e;
        logic [7:0] trio [3];
        n_total = 0;
        n_bad   = 0;
        trio[0] = 8'h11;
        trio[1] = 8'h22;
        trio[2] = 8'h33;
        model_reset();
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset values while held in reset
        #12;
        check("rst_out_data",  32'(bus.out_data),  32'h00);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_empty",     32'(bus.empty),     32'd1);
        check("rst_full",      32'(bus.full),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Three words presented continuously with the consumer stalled
        v = 0;
        for (int i = 0; i < 12 && v < 3; i++) begin
            cycle(1'b1, trio[v], 1'b0, acc);
            if (i == 1) check("trio_stall_cycle1", 32'(acc), 32'd0);
            if (acc) v++;
        end
        check("trio_head", 32'(bus.out_data), 32'h11);
        check("trio_count", 32'(bus.count), 32'd3);
        drain();

        // Fill to the brim: 33 accepted, the 34th refused
        v = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 8'(v), 1'b0, acc);
            if (acc) v++;
        end
        check("fill_accepted", 32'(v), 32'd33);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h21;
        #1;
        check("fill_full",     32'(bus.full),     32'd1);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_count",    32'(bus.count),    32'd33);
        @(negedge clk);

        // Drain one word per cycle in order
        e = 0;
        for (int i = 0; i < 60; i++) begin
            if (ram_q.size() == 0 && !m_ov) break;
            if (bus.out_valid) begin
                check("drain_seq", 32'(bus.out_data), 32'(e));
                e++;
            end
            cycle(1'b0, 8'h00, 1'b1, acc);
        end
        check("drain_words", 32'(e), 32'd33);
        check("drain_count", 32'(bus.count), 32'd0);

        // Contention: head valid, two in RAM, consumer taking -> push blocked
        cycle(1'b1, 8'hC1, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 8'hC2, 1'b0, acc);
        cycle(1'b1, 8'hC3, 1'b0, acc);
        check("cont_count3", 32'(bus.count), 32'd3);
        cycle(1'b1, 8'hC4, 1'b1, acc);
        check("cont_blocked", 32'(acc), 32'd0);
        drain();

        // ram_cnt==0 with a held head: push accepted, out_valid falls
        cycle(1'b1, 8'hD1, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, acc);
        check("zero_head_valid", 32'(bus.out_valid), 32'd1);
        cycle(1'b1, 8'hD2, 1'b1, acc);
        check("zero_push_acc", 32'(acc), 32'd1);
        check("zero_ov_fell", 32'(bus.out_valid), 32'd0);
        drain();

        // Streaming incrementing pattern across the pointer wrap
        v = 0;
        for (int i = 0; i < 300 && v < 40; i++) begin
            cycle(1'b1, 8'(8'h40 + v), 1'b1, acc);
            if (acc) v++;
        end
        check("wrap_pushes", 32'(v), 32'd40);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, acc);
        end
        drain();

        // Fill to 10 words then reset asynchronously mid-stream
        for (int i = 0; i < 60; i++) begin
            if (ram_q.size() + int'(m_ov) == 10) break;
            cycle(1'b1, 8'($urandom), 1'b0, acc);
        end
        check("pre_rst_count", 32'(bus.count), 32'd10);
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        #2;
        check("arst_count",     32'(bus.count),     32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_data",  32'(bus.out_data),  32'h00);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0, acc);
        check("post_rst_acc", 32'(acc), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, acc);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data",  32'(bus.out_data),  32'hA5);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
